// File: rtl/ysyx_24080014_mem_arbiter.sv
// Round-robin arbiter between IFU and LSU in front of the single memory access unit.
// A granted command is latched, issued until mem_ready or timeout, then answered with a one-cycle response.
module ysyx_24080014_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_gnt,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_err,
  input  logic              lsu_req,
  input  logic              lsu_wen,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [7:0]        lsu_wmask,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_err,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_din,
  output logic [7:0]        mem_wmask,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Count value of the last ISSUE cycle allowed before an error response.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state_r;
  logic              last_grant_r;   // 1 = LSU was granted last
  logic              owner_lsu_r;
  logic              wen_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] din_r;
  logic [7:0]        wmask_r;
  logic              mem_ren_r;
  logic              mem_wen_r;
  logic              ifu_rvalid_r;
  logic              lsu_rvalid_r;
  logic [DATA_W-1:0] rdata_r;
  logic              err_r;
  logic              ifu_gnt_s;
  logic              lsu_gnt_s;
  logic              expire_s;

  // Grant selection: combinational from requests while IDLE, forced low during reset.
  always_comb begin
    ifu_gnt_s = 1'b0;
    lsu_gnt_s = 1'b0;
    if (!rst && state_r == IDLE) begin
      if (ifu_req && lsu_req) begin
        ifu_gnt_s = last_grant_r;
        lsu_gnt_s = !last_grant_r;
      end else begin
        ifu_gnt_s = ifu_req;
        lsu_gnt_s = lsu_req;
      end
    end else begin
      ifu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end
  end

  assign expire_s = (cnt_r == CNT_LAST);

  // Sequencer: latch the winner's command, hold the memory handshake, produce the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b0;
      owner_lsu_r  <= 1'b0;
      wen_r        <= 1'b0;
      cnt_r        <= '0;
      addr_r       <= '0;
      din_r        <= '0;
      wmask_r      <= 8'h00;
      mem_ren_r    <= 1'b0;
      mem_wen_r    <= 1'b0;
      ifu_rvalid_r <= 1'b0;
      lsu_rvalid_r <= 1'b0;
      rdata_r      <= '0;
      err_r        <= 1'b0;
    end else begin
      ifu_rvalid_r <= 1'b0;
      lsu_rvalid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ifu_gnt_s || lsu_gnt_s) begin
            owner_lsu_r  <= lsu_gnt_s;
            last_grant_r <= lsu_gnt_s;
            wen_r        <= lsu_gnt_s & lsu_wen;
            addr_r       <= lsu_gnt_s ? lsu_addr : ifu_addr;
            din_r        <= lsu_gnt_s ? lsu_wdata : {DATA_W{1'b0}};
            wmask_r      <= (lsu_gnt_s & lsu_wen) ? lsu_wmask : 8'h00;
            mem_ren_r    <= !(lsu_gnt_s & lsu_wen);
            mem_wen_r    <= lsu_gnt_s & lsu_wen;
            cnt_r        <= '0;
            state_r      <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          // A ready arriving in the expiry cycle still wins over the timeout.
          if (mem_ready || expire_s) begin
            rdata_r      <= (mem_ready && !wen_r) ? mem_dout : {DATA_W{1'b0}};
            err_r        <= !mem_ready;
            mem_ren_r    <= 1'b0;
            mem_wen_r    <= 1'b0;
            ifu_rvalid_r <= !owner_lsu_r;
            lsu_rvalid_r <= owner_lsu_r;
            state_r      <= RESP;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ifu_gnt    = ifu_gnt_s;
  assign lsu_gnt    = lsu_gnt_s;
  assign ifu_rvalid = ifu_rvalid_r;
  assign lsu_rvalid = lsu_rvalid_r;
  assign ifu_rdata  = rdata_r;
  assign lsu_rdata  = rdata_r;
  assign ifu_err    = err_r;
  assign lsu_err    = err_r;
  assign mem_ren    = mem_ren_r;
  assign mem_wen    = mem_wen_r;
  assign mem_raddr  = addr_r;
  assign mem_waddr  = addr_r;
  assign mem_din    = din_r;
  assign mem_wmask  = wmask_r;

endmodule

// File: tb/tb_ysyx_24080014_mem_arbiter.sv
// Scoreboard bench for ysyx_24080014_mem_arbiter: a transaction-level model predicts grants,
// memory-side behaviour and responses; a separate monitor pops expected responses on rvalid.
module tb_ysyx_24080014_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic ifu_req, ifu_gnt, ifu_rvalid, ifu_err;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic lsu_req, lsu_wen, lsu_gnt, lsu_rvalid, lsu_err;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [7:0] lsu_wmask;
  logic mem_ren, mem_wen, mem_ready;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_din, mem_dout;
  logic [7:0] mem_wmask;

  ysyx_24080014_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_din(mem_din), .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          lsu;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, failures = 0, cyc = 0;
  // Model of the arbiter: cycle it is next free, current transaction window and memory plan.
  int idle_cyc = 0, t_issue = 0, t_ready = 0, t_resp = 0;
  int force_d = -1, writes = 0, grants = 0;
  bit last_lsu = 1'b0, t_store = 1'b0, g_i = 1'b0, g_l = 1'b0, use_val = 1'b0;
  logic [7:0] glog = 8'h00;
  logic [31:0] t_addr = 32'h0, t_din = 32'h0, t_val = 32'h0, force_val = 32'h0;
  logic [7:0] t_mask = 8'h00;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic chk_zero(string tag);
    chk({tag, "_ifu_gnt"}, ifu_gnt, 0);      chk({tag, "_lsu_gnt"}, lsu_gnt, 0);
    chk({tag, "_ifu_rvalid"}, ifu_rvalid, 0); chk({tag, "_lsu_rvalid"}, lsu_rvalid, 0);
    chk({tag, "_ifu_rdata"}, ifu_rdata, 0);  chk({tag, "_lsu_rdata"}, lsu_rdata, 0);
    chk({tag, "_ifu_err"}, ifu_err, 0);      chk({tag, "_lsu_err"}, lsu_err, 0);
    chk({tag, "_mem_ren"}, mem_ren, 0);      chk({tag, "_mem_wen"}, mem_wen, 0);
    chk({tag, "_mem_raddr"}, mem_raddr, 0);  chk({tag, "_mem_waddr"}, mem_waddr, 0);
    chk({tag, "_mem_din"}, mem_din, 0);      chk({tag, "_mem_wmask"}, mem_wmask, 0);
  endtask

  // Memory: ready exactly at the planned cycle inside the issue window, random noise elsewhere.
  task automatic drive_mem();
    if (cyc >= t_issue && cyc < t_resp) begin
      mem_ready = (cyc == t_ready);
      mem_dout  = (cyc == t_ready) ? t_val : $urandom;
    end else begin
      mem_ready = ($urandom_range(0, 1) == 1);
      mem_dout  = $urandom;
    end
  endtask

  task automatic check_cycle();
    bit ei, el, iss;
    int d;
    exp_t e;
    ei = 1'b0;
    el = 1'b0;
    if (cyc >= idle_cyc) begin
      if (ifu_req && lsu_req) begin
        el = !last_lsu;
        ei = last_lsu;
      end else begin
        ei = ifu_req;
        el = lsu_req;
      end
    end
    chk("ifu_gnt", ifu_gnt, ei);
    chk("lsu_gnt", lsu_gnt, el);
    iss = (cyc >= t_issue) && (cyc < t_resp);
    chk("mem_ren", mem_ren, iss && !t_store);
    chk("mem_wen", mem_wen, iss && t_store);
    if (iss) begin
      chk("mem_raddr", mem_raddr, t_addr);
      chk("mem_waddr", mem_waddr, t_addr);
      chk("mem_din", mem_din, t_din);
      chk("mem_wmask", mem_wmask, t_mask);
    end
    if (mem_wen && mem_ready) writes++;
    g_i = ei;
    g_l = el;
    if (ei || el) begin
      d = (force_d >= 0) ? force_d : $urandom_range(0, 5);
      grants++;
      glog = {glog[6:0], el};
      t_store = el && lsu_wen;
      t_addr = el ? lsu_addr : ifu_addr;
      t_din = el ? lsu_wdata : 32'h0;
      t_mask = t_store ? lsu_wmask : 8'h00;
      t_val = use_val ? force_val : $urandom;
      t_issue = cyc + 1;
      t_ready = t_issue + d;
      // Response follows the ready cycle, or the last of TO issue cycles.
      t_resp = t_issue + 1 + ((d < TO) ? d : TO - 1);
      idle_cyc = t_resp + 1;
      last_lsu = el;
      e.lsu = el;
      e.err = (d >= TO);
      e.rdata = (t_store || d >= TO) ? 32'h0 : t_val;
      e.cyc = t_resp;
      sb.push_back(e);
    end
  endtask

  task automatic step();
    drive_mem();
    #2;
    check_cycle();
    @(negedge clk);
    cyc++;
  endtask

  task automatic rand_reqs();
    if (g_i || (!ifu_req && $urandom_range(0, 2) == 0)) begin
      ifu_req = g_i ? ($urandom_range(0, 1) == 1) : 1'b1;
      ifu_addr = $urandom;
    end else if (ifu_req && $urandom_range(0, 7) == 0) begin
      ifu_req = 1'b0;
    end
    if (g_l || (!lsu_req && $urandom_range(0, 2) == 0)) begin
      lsu_req = g_l ? ($urandom_range(0, 1) == 1) : 1'b1;
      lsu_wen = ($urandom_range(0, 1) == 1);
      lsu_addr = $urandom;
      lsu_wdata = $urandom;
      lsu_wmask = 8'($urandom);
    end else if (lsu_req && $urandom_range(0, 7) == 0) begin
      lsu_req = 1'b0;
    end
  endtask

  // Monitor: every rvalid must match the oldest outstanding expectation, on its cycle.
  always @(negedge clk) begin
    #3;
    if (!rst) begin
      if (ifu_rvalid || lsu_rvalid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rvalid_unexpected: ifu_rvalid=%0b lsu_rvalid=%0b with nothing outstanding (cycle %0d)",
                   ifu_rvalid, lsu_rvalid, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("rvalid_cycle", cyc, mon_e.cyc);
          chk("rvalid_ifu", ifu_rvalid, !mon_e.lsu);
          chk("rvalid_lsu", lsu_rvalid, mon_e.lsu);
          chk("rdata", mon_e.lsu ? lsu_rdata : ifu_rdata, mon_e.rdata);
          chk("err", mon_e.lsu ? lsu_err : ifu_err, mon_e.err);
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        checks++;
        failures++;
        $display("FAIL rvalid_missing: got none, expected response due at cycle %0d (now %0d)", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifu_req = 1'b1; lsu_req = 1'b1; lsu_wen = 1'b1;
    ifu_addr = 32'h1234_5678; lsu_addr = 32'h8765_4321;
    lsu_wdata = 32'hFFFF_FFFF; lsu_wmask = 8'hFF;
    mem_ready = 1'b1; mem_dout = 32'hFFFF_FFFF;
    @(negedge clk);
    #2;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    // Both held after reset: LSU, IFU, LSU, IFU, one every 4 cycles.
    lsu_wen = 1'b0;
    force_d = 1;
    grants = 0;
    glog = 8'h00;
    repeat (16) step();
    ifu_req = 1'b0; lsu_req = 1'b0;
    repeat (4) step();
    chk("tie_grant_count", grants, 4);
    chk("tie_grant_order", glog[3:0], 4'b1010);

    // IFU fetch, memory answers one cycle after ren.
    ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
    use_val = 1'b1; force_val = 32'h0000_0413; force_d = 1;
    step();
    ifu_req = 1'b0;
    repeat (5) step();

    // LSU store with a few wait cycles; one memory write.
    lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0100;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F; force_d = 3; writes = 0;
    step();
    lsu_req = 1'b0;
    repeat (6) step();
    chk("store_write_count", writes, 1);

    // Timeout, then ready arriving exactly in the expiry cycle.
    use_val = 1'b0;
    ifu_req = 1'b1; ifu_addr = 32'h8000_0040; force_d = 99;
    step();
    ifu_req = 1'b0;
    repeat (7) step();
    ifu_req = 1'b1; ifu_addr = 32'h8000_0044; force_d = TO - 1;
    step();
    ifu_req = 1'b0;
    repeat (7) step();

    // Randomised traffic with random memory latency (some beyond the timeout).
    force_d = -1;
    repeat (400) begin
      rand_reqs();
      step();
    end
    ifu_req = 1'b0; lsu_req = 1'b0;
    repeat (10) step();

    // Reset while a store is being issued.
    lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0200;
    lsu_wdata = 32'h0BAD_F00D; lsu_wmask = 8'hF0; force_d = 99;
    step();
    lsu_req = 1'b0;
    step();
    chk("pre_reset_wen", mem_wen, 1);
    rst = 1'b1; ifu_req = 1'b1; lsu_req = 1'b1;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    cyc++;
    sb.delete();
    idle_cyc = cyc; t_issue = 0; t_resp = 0; last_lsu = 1'b0;
    grants = 0; glog = 8'h00; force_d = 1;
    step();
    ifu_req = 1'b0; lsu_req = 1'b0;
    repeat (8) step();
    chk("reset_tie_winner", glog[1:0], 2'b01);
    chk("scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
